// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter slice.
package wb_pkg;

  localparam int WB_DATA_W = 32;

  // Register index of the program counter; writes to it are never committed.
  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [15:0] onehot16(input logic [3:0] rd);
    onehot16 = 16'd1 << rd;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result-source and register-bank write-port bundle for the writeback arbiter.
interface writeback_arbiter_if #(
  parameter int DATA_W = 32
) ();

  logic              alu_valid;
  logic [3:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [3:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [DATA_W-1:0] pc_in;
  logic              we3;
  logic [3:0]        a3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] r15_out;
  logic [15:0]       pend_mask;
  logic              buf_empty;
  logic              err_pc_wr;

  // Upstream view: result producers and the register bank consumer.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output pc_in,
    input  ld_ready, we3, a3, wd3, r15_out, pend_mask, buf_empty, err_pc_wr
  );

  // Arbiter view.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  pc_in,
    output ld_ready, we3, a3, wd3, r15_out, pend_mask, buf_empty, err_pc_wr
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending load writes with kill-by-destination support.
// Killed entries keep their slot and are still popped in order.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [3:0]             i_push_rd,
  input  logic [DATA_W-1:0]      i_push_data,
  input  logic                   i_pop,
  input  logic                   i_kill,
  input  logic [3:0]             i_kill_rd,
  output logic                   o_head_valid,
  output logic [3:0]             o_head_rd,
  output logic [DATA_W-1:0]      o_head_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DEPTH-1:0]       o_vld,
  output logic [DEPTH*4-1:0]     o_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  r_vld;
  logic [3:0]        r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic [DEPTH-1:0]  w_vld_nxt;
  logic [PTR_W:0]    w_count_nxt;

  // Next valid vector and occupancy from kill, pop and push requests.
  always_comb begin
    w_vld_nxt   = r_vld;
    w_count_nxt = r_count;
    if (i_kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_rd[i] == i_kill_rd) w_vld_nxt[i] = 1'b0;
      end
    end
    if (i_pop)  w_vld_nxt[r_head] = 1'b0;
    if (i_push) w_vld_nxt[r_tail] = 1'b1;
    if (i_push && !i_pop)      w_count_nxt = r_count + 1'b1;
    else if (i_pop && !i_push) w_count_nxt = r_count - 1'b1;
  end

  // Control state: valid bits, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_vld   <= w_vld_nxt;
      r_count <= w_count_nxt;
      if (i_pop)  r_head <= r_head + 1'b1;
      if (i_push) r_tail <= r_tail + 1'b1;
    end
  end

  // Entry payload storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_tail]   <= i_push_rd;
      r_data[r_tail] <= i_push_data;
    end
  end

  // Flatten entry destinations for the pending-write mask.
  always_comb begin
    o_rd = '0;
    for (int i = 0; i < DEPTH; i++) o_rd[i*4 +: 4] = r_rd[i];
  end

  assign o_head_valid = r_vld[r_head];
  assign o_head_rd    = r_rd[r_head];
  assign o_head_data  = r_data[r_head];
  assign o_count      = r_count;
  assign o_vld        = r_vld;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns into the
// register bank's single write port, filters PC writes and publishes the
// set of registers with queued writes.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst,
  writeback_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              w_head_valid;
  logic [3:0]        w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic [CNT_W-1:0]  w_count;
  logic [DEPTH-1:0]  w_vld;
  logic [DEPTH*4-1:0] w_rd_vec;

  logic              w_empty;
  logic              w_full;
  logic              w_ld_acc;
  logic              w_ld_drop;
  logic              w_bypass;
  logic              w_pop;
  logic              w_push;
  logic              w_sel_we;
  logic [3:0]        w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_we;
  logic              w_err;
  logic [15:0]       w_pend;

  logic              r_we3_p1;
  logic [3:0]        r_a3_p1;
  logic [DATA_W-1:0] r_wd3_p1;
  logic [DATA_W-1:0] r_r15_p1;
  logic              r_err_p1;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_rd    (bus.ld_rd),
    .i_push_data  (bus.ld_data),
    .i_pop        (w_pop),
    .i_kill       (bus.alu_valid),
    .i_kill_rd    (bus.alu_rd),
    .o_head_valid (w_head_valid),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .o_count      (w_count),
    .o_vld        (w_vld),
    .o_rd         (w_rd_vec)
  );

  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == CNT_W'(DEPTH));
  assign w_ld_acc = bus.ld_valid && !w_full;

  // Write select: ALU first, then buffer head, then direct load bypass.
  // A load is dropped (handshake still completes) when it targets the PC or
  // the same register as a simultaneous, younger ALU result.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    w_pop      = 1'b0;
    w_bypass   = 1'b0;
    if (bus.alu_valid) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = bus.alu_rd;
      w_sel_data = bus.alu_data;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_sel_we   = w_head_valid;
      w_sel_rd   = w_head_rd;
      w_sel_data = w_head_data;
    end else if (bus.ld_valid) begin
      w_bypass   = 1'b1;
      w_sel_we   = 1'b1;
      w_sel_rd   = bus.ld_rd;
      w_sel_data = bus.ld_data;
    end
    w_ld_drop = (bus.alu_valid && (bus.ld_rd == bus.alu_rd)) ||
                (bus.ld_rd == REG_PC);
    w_push    = w_ld_acc && !w_bypass && !w_ld_drop;
    w_we      = w_sel_we && (w_sel_rd != REG_PC);
    w_err     = (bus.alu_valid && (bus.alu_rd == REG_PC)) ||
                (w_ld_acc && (bus.ld_rd == REG_PC));
  end

  // Pending-write mask from queued valid entries only.
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i]) w_pend = w_pend | onehot16(w_rd_vec[i*4 +: 4]);
    end
  end

  // ---- stage p0 -> p1: registered bank write port, PC view and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3_p1 <= 1'b0;
      r_a3_p1  <= '0;
      r_wd3_p1 <= '0;
      r_r15_p1 <= '0;
      r_err_p1 <= 1'b0;
    end else begin
      r_we3_p1 <= w_we;
      r_a3_p1  <= w_sel_rd;
      r_wd3_p1 <= w_sel_data;
      r_r15_p1 <= bus.pc_in + DATA_W'(PC_OFFSET);
      r_err_p1 <= w_err;
    end
  end

  assign bus.ld_ready  = !w_full;
  assign bus.we3       = r_we3_p1;
  assign bus.a3        = r_a3_p1;
  assign bus.wd3       = r_wd3_p1;
  assign bus.r15_out   = r_r15_p1;
  assign bus.pend_mask = w_pend;
  assign bus.buf_empty = w_empty;
  assign bus.err_pc_wr = r_err_p1;

endmodule
